// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule emitting round keys 0..10 over valid/ready.
module aes_key_expand (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key_in,
    input  logic         i_rk_ready,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_num,
    output logic         o_rk_valid,
    output logic         o_busy,
    output logic         o_done
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t       r_state;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_num;
    logic         r_rk_valid;
    logic         r_busy;
    logic         r_done;
    logic [3:0]   w_rc_idx;
    logic [7:0]   w_rc;
    logic [31:0]  w_rot;
    logic [31:0]  w_t;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    assign w_rc_idx = r_round_num + 4'd1;
    always_comb begin
        case (w_rc_idx)
            4'd1:    w_rc = 8'h01;
            4'd2:    w_rc = 8'h02;
            4'd3:    w_rc = 8'h04;
            4'd4:    w_rc = 8'h08;
            4'd5:    w_rc = 8'h10;
            4'd6:    w_rc = 8'h20;
            4'd7:    w_rc = 8'h40;
            4'd8:    w_rc = 8'h80;
            4'd9:    w_rc = 8'h1b;
            4'd10:   w_rc = 8'h36;
            default: w_rc = 8'h00;
        endcase
    end
    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};
    assign w_t   = {SBOX[w_rot[31:24]] ^ w_rc, SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
    assign w_w0  = r_round_key[127:96] ^ w_t;
    assign w_w1  = r_round_key[95:64] ^ w_w0;
    assign w_w2  = r_round_key[63:32] ^ w_w1;
    assign w_w3  = r_round_key[31:0] ^ w_w2;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_round_key <= '0;
            r_round_num <= '0;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    r_state     <= S_RUN;
                    r_round_key <= i_key_in;
                    r_round_num <= 4'd0;
                    r_rk_valid  <= 1'b1;
                    r_busy      <= 1'b1;
                end
            end else if (i_rk_ready) begin
                // valid is always high in RUN, so ready alone marks a handshake
                if (r_round_num == 4'd10) begin
                    r_state    <= S_IDLE;
                    r_rk_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end else begin
                    r_round_key <= {w_w0, w_w1, w_w2, w_w3};
                    r_round_num <= w_rc_idx;
                end
            end
        end
    end
    assign o_round_key = r_round_key;
    assign o_round_num = r_round_num;
    assign o_rk_valid  = r_rk_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed-vector bench for the AES-128 key schedule generator.
module tb_aes_key_expand;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [127:0] key_in = '0;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         rk_valid;
    logic         busy;
    logic         done;
    logic [134:0] obs;
    logic [127:0] fips [0:10];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    assign obs = {rk_valid, busy, done, round_num, round_key};
    aes_key_expand dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_key_in(key_in),
        .i_rk_ready(rk_ready),
        .o_round_key(round_key),
        .o_round_num(round_num),
        .o_rk_valid(rk_valid),
        .o_busy(busy),
        .o_done(done)
    );
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", obs); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_released: got %h expected 0", obs); end
    endtask
    task automatic test_fips_vector();
        logic [134:0] exp;
        key_in = FIPS_KEY;
        start = 1'b1;
        rk_ready = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            key_in = '1;
            exp = (c <= 11) ? {3'b110, 4'(c - 1), fips[c - 1]} :
                  (c == 12) ? {3'b001, 4'd10, fips[10]} : {3'b000, 4'd10, fips[10]};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL fips cycle %0d: got %h expected %h", c, obs, exp); end
        end
    endtask
    task automatic test_backpressure();
        logic [134:0] exp;
        int k = 0;
        key_in = FIPS_KEY;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = (c <= 14) ? {3'b110, 4'(k), fips[k]} : {3'b001, 4'd10, fips[10]};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL backpressure cycle %0d: got %h expected %h", c, obs, exp); end
            rk_ready = !(c >= 5 && c <= 7);
            if (rk_ready && k < 10) k++;
        end
        rk_ready = 1'b1;
    endtask
    task automatic test_start_while_busy();
        logic [134:0] exp;
        key_in = FIPS_KEY;
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp = (c <= 11) ? {3'b110, 4'(c - 1), fips[c - 1]} :
                  (c == 12) ? {3'b001, 4'd10, fips[10]} : {3'b000, 4'd10, fips[10]};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL start_busy cycle %0d: got %h expected %h", c, obs, exp); end
            start = (c == 6);
            key_in = (c == 6) ? '1 : FIPS_KEY;
        end
        start = 1'b0;
    endtask
    task automatic test_mid_reset();
        logic [134:0] exp;
        key_in = FIPS_KEY;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = {3'b110, 4'(c - 1), fips[c - 1]};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL pre_reset cycle %0d: got %h expected %h", c, obs, exp); end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset_no_done %0d: got %h expected 0", c, obs); end
        end
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = (c <= 11) ? {3'b110, 4'(c - 1), fips[c - 1]} : {3'b001, 4'd10, fips[10]};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL post_reset cycle %0d: got %h expected %h", c, obs, exp); end
        end
    endtask
    task automatic test_back_to_back();
        logic [134:0] exp;
        logic seen = 1'b0;
        key_in = '0;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = (c == 1)  ? {3'b110, 4'd0, 128'h0} :
                  (c == 2)  ? {3'b110, 4'd1, ZERO_R1} :
                  (c == 11) ? {3'b110, 4'd10, ZERO_R10} : {3'b001, 4'd10, ZERO_R10};
            if (c == 1 || c == 2 || c >= 11) begin
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL zero_key cycle %0d: got %h expected %h", c, obs, exp); end
            end
        end
        key_in = FIPS_KEY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs !== {3'b110, 4'd0, FIPS_KEY}) begin
            errors++; $display("FAIL back_to_back_round0: got %h expected %h", obs, {3'b110, 4'd0, FIPS_KEY});
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (seen !== 1'b1 || round_key !== fips[10]) begin
            errors++; $display("FAIL back_to_back_done: got done %b key %h expected done 1 key %h", seen, round_key, fips[10]);
        end
    endtask
    initial begin
        fips[0]  = FIPS_KEY;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
